vector_permute_seq: RTL and testbench
=====================================

Name: vector_permute_seq

Overview:
Issue controller for the vector permute unit (pack/unpack, splat, shift, select). It accepts permute instructions over a valid/ready handshake and drives the permute control interface, including the result-register enable. It splits the two-pass macro ops UNPACK_FULL and PACK_FULL into two micro-ops written to consecutive destination registers. It also holds the registered permute result until the vector register file accepts the writeback.

Parameters:
NUM_ELEMS, 8, vector elements (passed through for documentation/assertions)
ELEM_SIZE, 16, element width in bits; in_g width
DEST_W, 5, destination register index width
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  instruction valid
in_ready  out  1  instruction consumed this cycle
in_op  in  4  0 PACK_HI, 1 PACK_LO, 2 UNPACK_L, 3 UNPACK_R, 4 SPLAT, 5 SPLATB, 6 SHIFT, 7 SHIFTB, 8 SELECT, 9 UNPACK_FULL, 10 PACK_FULL, 11-15 illegal
in_size  in  3  pack/unpack size field; for SELECT, the condition code
in_shift  in  5  signed shift amount
in_g  in  ELEM_SIZE  splat value
in_dest  in  DEST_W  destination register
p_op  out  Vector permute op  PERMUTE_PACK/SPLAT/SPLATB/SHIFT/SHIFTB/SELECT
p_size, p_shift, p_g  out  3/5/ELEM_SIZE  forwarded fields
p_pack_upper, p_pack_lower, p_unpack_left, p_unpack_right  out  1 each  one-hot mode; all 0 for non-pack ops
p_keep_res  out  1  permute result register load enable
wb_valid  out  1  permute result valid for writeback
wb_ready  in  1  register file accepts writeback
wb_dest  out  DEST_W  writeback destination
wb_last  out  1  final micro-op of its instruction
err  out  1  one-cycle pulse: illegal op dropped
cnt_issue  out  CNT_W  micro-ops issued
cnt_stall  out  CNT_W  cycles a legal op was blocked by writeback

Behaviour:
- Reset values: wb_valid=0, wb_dest=0, wb_last=0, err=0, pass=0, both counters=0. Combinational outputs follow from reset state: in_ready=0, p_keep_res=0.
- slot_free = !wb_valid | wb_ready.
- issue = in_valid & legal(in_op) & slot_free.
- p_keep_res = issue. The permute result is registered, so a result is available one cycle after issue.
- Upstream holds in_* and the permute operands stable while in_valid & !in_ready.
- Single-pass ops: in_ready = issue.
- Two-pass ops use the pass register.
  - pass=0: issue gives in_ready=0, then pass<=1.
  - pass=1: issue gives in_ready=1, then pass<=0.
  - UNPACK_FULL: pass0 = unpack_left, pass1 = unpack_right.
  - PACK_FULL: pass0 = pack_upper, pass1 = pack_lower.
- Combinational decode:
  - p_op is PACK for ops 0-3, 9 and 10; otherwise p_op follows in_op.
  - One-hot mode bits come from in_op and pass.
  - p_size, p_shift and p_g are passed through.
  - When !in_valid, all p_* outputs are 0.
- Writeback registers:
  - On issue: wb_valid<=1, wb_dest<=in_dest+pass (modulo 2^DEST_W; dest 31 wraps to 0), wb_last<=(single-pass | pass==1).
  - Else if wb_ready: wb_valid<=0.
  - Issue and wb_ready in the same cycle: the new result replaces the drained one. This sustains 1 micro-op/cycle.
- Back-pressure: while wb_valid & !wb_ready, p_keep_res=0 so the permute output register holds; wb_dest/wb_last hold.
- Illegal op (in_valid, op 11-15):
  - in_ready=1 in the same cycle, regardless of slot_free.
  - No p_keep_res, no writeback.
  - err=1 in the following cycle.
  - pass is unaffected; illegal ops only arrive when pass=0.
- Counters (wrap at 2^CNT_W):
  - cnt_issue increments on each issue.
  - cnt_stall increments when in_valid & legal & !slot_free.
- Reset mid two-pass op: pass returns to 0. Upstream still holds the instruction and it restarts from pass0; any pending writeback is discarded.
- No internal queueing: at most one result is outstanding.

Test Plan:
- SPLAT g=0x00AB, dest=3, wb_ready=1 → in_ready & p_keep_res in cycle t, p_op=SPLAT, p_g=0x00AB; wb_valid=1, wb_dest=3, wb_last=1 at t+1; cnt_issue=1.
- UNPACK_FULL size=2, dest=31, wb_ready=1 → t: unpack_left=1, in_ready=0; t+1: unpack_right=1, in_ready=1, wb_dest=31, wb_last=0; t+2: wb_dest=0, wb_last=1.
- SHIFT sh=-3 with wb_ready held low 4 cycles after first result → p_keep_res=0 and wb_valid=1 throughout; the next queued op issues in the same cycle wb_ready rises; cnt_stall=4.
- Back-to-back 5 SELECT ops (size=cond 1), wb_ready=1 → 5 consecutive issue cycles, 5 consecutive wb_valid cycles, no bubbles.
- in_op=12 → in_ready=1 with no p_keep_res, err pulse next cycle, no wb_valid; the next legal op proceeds normally.
- PACK_FULL: assert reset after pass0 issues, hold instruction → all outputs return to reset values; after release, pack_upper is reissued first, then pack_lower.

Source files
------------

// File: rtl/vector_permute_seq.sv
// Issue controller for the vector permute unit: decodes permute ops, splits two-pass macro ops, holds the writeback.
// Latency: control is combinational in the issue cycle; the writeback is valid one cycle after each micro-op issues.
// Backpressure: while a writeback is held, p_keep_res stays low and legal ops stall; illegal ops are always dropped at once.
module vector_permute_seq #(
    parameter int NUM_ELEMS = 8,
    parameter int ELEM_SIZE = 16,
    parameter int DEST_W    = 5,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_op,
    input  logic [2:0]           in_size,
    input  logic [4:0]           in_shift,
    input  logic [ELEM_SIZE-1:0] in_g,
    input  logic [DEST_W-1:0]    in_dest,
    output logic [2:0]           p_op,
    output logic [2:0]           p_size,
    output logic [4:0]           p_shift,
    output logic [ELEM_SIZE-1:0] p_g,
    output logic                 p_pack_upper,
    output logic                 p_pack_lower,
    output logic                 p_unpack_left,
    output logic                 p_unpack_right,
    output logic                 p_keep_res,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [DEST_W-1:0]    wb_dest,
    output logic                 wb_last,
    output logic                 err,
    output logic [CNT_W-1:0]     cnt_issue,
    output logic [CNT_W-1:0]     cnt_stall
);

    localparam logic [3:0] OP_PACK_HI     = 4'd0;
    localparam logic [3:0] OP_PACK_LO     = 4'd1;
    localparam logic [3:0] OP_UNPACK_L    = 4'd2;
    localparam logic [3:0] OP_UNPACK_R    = 4'd3;
    localparam logic [3:0] OP_SPLAT       = 4'd4;
    localparam logic [3:0] OP_SPLATB      = 4'd5;
    localparam logic [3:0] OP_SHIFT       = 4'd6;
    localparam logic [3:0] OP_SHIFTB      = 4'd7;
    localparam logic [3:0] OP_SELECT      = 4'd8;
    localparam logic [3:0] OP_UNPACK_FULL = 4'd9;
    localparam logic [3:0] OP_PACK_FULL   = 4'd10;

    localparam logic [2:0] PERMUTE_PACK   = 3'd0;
    localparam logic [2:0] PERMUTE_SPLAT  = 3'd1;
    localparam logic [2:0] PERMUTE_SPLATB = 3'd2;
    localparam logic [2:0] PERMUTE_SHIFT  = 3'd3;
    localparam logic [2:0] PERMUTE_SHIFTB = 3'd4;
    localparam logic [2:0] PERMUTE_SELECT = 3'd5;

    logic pass;
    logic legal;
    logic two_pass;
    logic slot_free;
    logic issue;
    logic drop;

    always_comb begin
        legal     = (in_op <= OP_PACK_FULL);
        two_pass  = (in_op == OP_UNPACK_FULL) || (in_op == OP_PACK_FULL);
        slot_free = !wb_valid || wb_ready;
        // Handshake is gated by reset so nothing is accepted while the sequencer is being cleared.
        issue     = in_valid && legal && slot_free && !reset;
        drop      = in_valid && !legal && !reset;
        in_ready  = drop || (issue && (!two_pass || pass));
        p_keep_res = issue;
    end

    always_comb begin
        p_op           = PERMUTE_PACK;
        p_size         = '0;
        p_shift        = '0;
        p_g            = '0;
        p_pack_upper   = 1'b0;
        p_pack_lower   = 1'b0;
        p_unpack_left  = 1'b0;
        p_unpack_right = 1'b0;
        if (in_valid) begin
            p_size  = in_size;
            p_shift = in_shift;
            p_g     = in_g;
            case (in_op)
                OP_PACK_HI:     p_pack_upper   = 1'b1;
                OP_PACK_LO:     p_pack_lower   = 1'b1;
                OP_UNPACK_L:    p_unpack_left  = 1'b1;
                OP_UNPACK_R:    p_unpack_right = 1'b1;
                OP_SPLAT:       p_op = PERMUTE_SPLAT;
                OP_SPLATB:      p_op = PERMUTE_SPLATB;
                OP_SHIFT:       p_op = PERMUTE_SHIFT;
                OP_SHIFTB:      p_op = PERMUTE_SHIFTB;
                OP_SELECT:      p_op = PERMUTE_SELECT;
                OP_UNPACK_FULL: begin
                    p_unpack_left  = !pass;
                    p_unpack_right = pass;
                end
                OP_PACK_FULL: begin
                    p_pack_upper = !pass;
                    p_pack_lower = pass;
                end
                default: p_op = PERMUTE_PACK;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass      <= 1'b0;
            wb_valid  <= 1'b0;
            wb_dest   <= '0;
            wb_last   <= 1'b0;
            err       <= 1'b0;
            cnt_issue <= '0;
            cnt_stall <= '0;
        end else begin
            err <= drop;
            // A new issue overwrites a result draining in the same cycle, sustaining one micro-op per cycle.
            if (issue) begin
                wb_valid  <= 1'b1;
                wb_dest   <= in_dest + DEST_W'(pass);
                wb_last   <= !two_pass || pass;
                cnt_issue <= cnt_issue + CNT_W'(1);
                if (two_pass) begin
                    pass <= !pass;
                end
            end else if (wb_ready) begin
                wb_valid <= 1'b0;
            end
            if (in_valid && legal && !slot_free) begin
                cnt_stall <= cnt_stall + CNT_W'(1);
            end
        end
    end

    a_params: assert property (@(posedge clk) (NUM_ELEMS > 0) && (ELEM_SIZE > 0));
    a_wb_hold: assert property (@(posedge clk) disable iff (reset)
        (wb_valid && !wb_ready) |=> (wb_valid && $stable(wb_dest) && $stable(wb_last)));

endmodule

// File: tb/tb_vector_permute_seq.sv
// Bench for vector_permute_seq: table-driven decode vectors plus stall, streaming and reset sequences.
module tb_vector_permute_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [2:0]  in_size;
    logic [4:0]  in_shift;
    logic [15:0] in_g;
    logic [4:0]  in_dest;
    logic [2:0]  p_op;
    logic [2:0]  p_size;
    logic [4:0]  p_shift;
    logic [15:0] p_g;
    logic        p_pack_upper;
    logic        p_pack_lower;
    logic        p_unpack_left;
    logic        p_unpack_right;
    logic        p_keep_res;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_dest;
    logic        wb_last;
    logic        err;
    logic [31:0] cnt_issue;
    logic [31:0] cnt_stall;

    vector_permute_seq #(.NUM_ELEMS(8), .ELEM_SIZE(16), .DEST_W(5), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_size(in_size),
        .in_shift(in_shift), .in_g(in_g), .in_dest(in_dest),
        .p_op(p_op), .p_size(p_size), .p_shift(p_shift), .p_g(p_g),
        .p_pack_upper(p_pack_upper), .p_pack_lower(p_pack_lower),
        .p_unpack_left(p_unpack_left), .p_unpack_right(p_unpack_right),
        .p_keep_res(p_keep_res), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_dest(wb_dest), .wb_last(wb_last), .err(err),
        .cnt_issue(cnt_issue), .cnt_stall(cnt_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  size;
        logic [4:0]  shift;
        logic [15:0] g;
        logic [4:0]  dest;
        logic [2:0]  pop;
        logic [3:0]  mode0;
        logic [3:0]  mode1;
        bit          two;
        bit          ill;
    } vec_t;

    typedef struct {
        logic [4:0] dest;
        logic       last;
    } wb_t;

    vec_t tbl[12];
    wb_t  sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] mode();
        return {p_pack_upper, p_pack_lower, p_unpack_left, p_unpack_right};
    endfunction

    task automatic push(input logic [4:0] d, input logic l);
        wb_t e;
        e.dest = d;
        e.last = l;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [3:0] op, input logic [2:0] size, input logic [4:0] sh,
                         input logic [15:0] g, input logic [4:0] d);
        in_valid = 1'b1;
        in_op    = op;
        in_size  = size;
        in_shift = sh;
        in_g     = g;
        in_dest  = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every accepted writeback must match the oldest expected micro-op.
    always @(negedge clk) begin
        if (!reset && wb_valid && wb_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected actual dest=%0d expected none", wb_dest);
            end else begin
                wb_t e;
                e = sb.pop_front();
                chk("sb_dest", 32'(wb_dest), 32'(e.dest));
                chk("sb_last", 32'(wb_last), 32'(e.last));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] d1;
        tbl[0]  = '{4'd0,  3'd1, 5'd0,    16'h0000, 5'd1,  3'd0, 4'b1000, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{4'd1,  3'd2, 5'd0,    16'h0000, 5'd2,  3'd0, 4'b0100, 4'b0000, 1'b0, 1'b0};
        tbl[2]  = '{4'd2,  3'd3, 5'd0,    16'h0000, 5'd4,  3'd0, 4'b0010, 4'b0000, 1'b0, 1'b0};
        tbl[3]  = '{4'd3,  3'd4, 5'd0,    16'h0000, 5'd5,  3'd0, 4'b0001, 4'b0000, 1'b0, 1'b0};
        tbl[4]  = '{4'd4,  3'd0, 5'd0,    16'h00AB, 5'd3,  3'd1, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[5]  = '{4'd5,  3'd0, 5'd0,    16'h1234, 5'd6,  3'd2, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[6]  = '{4'd6,  3'd0, 5'h1D,   16'h0000, 5'd7,  3'd3, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[7]  = '{4'd7,  3'd0, 5'h05,   16'h0000, 5'd8,  3'd4, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[8]  = '{4'd8,  3'd1, 5'd0,    16'h0000, 5'd9,  3'd5, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[9]  = '{4'd9,  3'd2, 5'd0,    16'h0000, 5'd31, 3'd0, 4'b0010, 4'b0001, 1'b1, 1'b0};
        tbl[10] = '{4'd12, 3'd0, 5'd0,    16'h0000, 5'd11, 3'd0, 4'b0000, 4'b0000, 1'b0, 1'b1};
        tbl[11] = '{4'd10, 3'd3, 5'd0,    16'h0000, 5'd15, 3'd0, 4'b1000, 4'b0100, 1'b1, 1'b0};

        reset = 1'b1;
        wb_ready = 1'b0;
        in_valid = 1'b0;
        in_op = '0; in_size = '0; in_shift = '0; in_g = '0; in_dest = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_dest", 32'(wb_dest), 32'd0);
        chk("rst_wb_last", 32'(wb_last), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_keep", 32'(p_keep_res), 32'd0);
        chk("rst_cnt_issue", cnt_issue, 32'd0);
        chk("rst_cnt_stall", cnt_stall, 32'd0);
        next_cycle();
        reset = 1'b0;
        wb_ready = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].op, tbl[i].size, tbl[i].shift, tbl[i].g, tbl[i].dest);
            d1 = tbl[i].dest + 5'd1;
            @(negedge clk);
            chk("tbl_in_ready", 32'(in_ready), 32'(tbl[i].ill || !tbl[i].two));
            chk("tbl_keep", 32'(p_keep_res), 32'(!tbl[i].ill));
            chk("tbl_err_idle", 32'(err), 32'd0);
            if (!tbl[i].ill) begin
                chk("tbl_p_op", 32'(p_op), 32'(tbl[i].pop));
                chk("tbl_mode0", 32'(mode()), 32'(tbl[i].mode0));
                chk("tbl_p_size", 32'(p_size), 32'(tbl[i].size));
                chk("tbl_p_shift", 32'(p_shift), 32'(tbl[i].shift));
                chk("tbl_p_g", 32'(p_g), 32'(tbl[i].g));
                if (tbl[i].two) begin
                    push(tbl[i].dest, 1'b0);
                    push(d1, 1'b1);
                end else begin
                    push(tbl[i].dest, 1'b1);
                end
            end
            if (tbl[i].two) begin
                next_cycle();
                @(negedge clk);
                chk("tbl_mode1", 32'(mode()), 32'(tbl[i].mode1));
                chk("tbl_in_ready1", 32'(in_ready), 32'd1);
                chk("tbl_keep1", 32'(p_keep_res), 32'd1);
                chk("tbl_wb_dest0", 32'(wb_dest), 32'(tbl[i].dest));
                chk("tbl_wb_last0", 32'(wb_last), 32'd0);
            end
            next_cycle();
            in_valid = 1'b0;
            @(negedge clk);
            if (tbl[i].ill) begin
                chk("ill_err", 32'(err), 32'd1);
                chk("ill_wb_valid", 32'(wb_valid), 32'd0);
            end else begin
                chk("tbl_wb_valid", 32'(wb_valid), 32'd1);
                chk("tbl_wb_dest", 32'(wb_dest), tbl[i].two ? 32'(d1) : 32'(tbl[i].dest));
                chk("tbl_wb_last", 32'(wb_last), 32'd1);
            end
            next_cycle();
        end
        chk("tbl_cnt_issue", cnt_issue, 32'd13);

        // Writeback stall: SHIFT result held while the next op waits.
        drive(4'd6, 3'd0, 5'h1D, 16'h0000, 5'd7);
        @(negedge clk);
        chk("st_keep0", 32'(p_keep_res), 32'd1);
        chk("st_p_shift", 32'(p_shift), 32'h1D);
        push(5'd7, 1'b1);
        next_cycle();
        wb_ready = 1'b0;
        drive(4'd5, 3'd0, 5'd0, 16'h5A5A, 5'd9);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("st_keep_held", 32'(p_keep_res), 32'd0);
            chk("st_in_ready", 32'(in_ready), 32'd0);
            chk("st_wb_valid", 32'(wb_valid), 32'd1);
            chk("st_wb_dest", 32'(wb_dest), 32'd7);
            next_cycle();
        end
        wb_ready = 1'b1;
        @(negedge clk);
        chk("st_keep_resume", 32'(p_keep_res), 32'd1);
        chk("st_ready_resume", 32'(in_ready), 32'd1);
        push(5'd9, 1'b1);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("st_wb_dest_next", 32'(wb_dest), 32'd9);
        chk("st_cnt_stall", cnt_stall, 32'd4);
        next_cycle();

        // Five back-to-back SELECTs with no bubbles.
        for (int i = 0; i < 5; i++) begin
            drive(4'd8, 3'd1, 5'd0, 16'h0000, 5'(10 + i));
            @(negedge clk);
            chk("sel_in_ready", 32'(in_ready), 32'd1);
            chk("sel_keep", 32'(p_keep_res), 32'd1);
            chk("sel_p_op", 32'(p_op), 32'd5);
            if (i > 0) chk("sel_wb_valid", 32'(wb_valid), 32'd1);
            push(5'(10 + i), 1'b1);
            next_cycle();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("sel_wb_valid_last", 32'(wb_valid), 32'd1);
        chk("sel_wb_dest_last", 32'(wb_dest), 32'd14);
        next_cycle();
        next_cycle();
        chk("cnt_issue_total", cnt_issue, 32'd20);

        // Reset in the middle of PACK_FULL; the held instruction restarts at pass0.
        drive(4'd10, 3'd0, 5'd0, 16'h0000, 5'd20);
        @(negedge clk);
        chk("rp_mode0", 32'(mode()), 32'b1000);
        chk("rp_in_ready0", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        chk("rp_wb_valid", 32'(wb_valid), 32'd0);
        chk("rp_wb_dest", 32'(wb_dest), 32'd0);
        chk("rp_wb_last", 32'(wb_last), 32'd0);
        chk("rp_err", 32'(err), 32'd0);
        chk("rp_in_ready", 32'(in_ready), 32'd0);
        chk("rp_keep", 32'(p_keep_res), 32'd0);
        chk("rp_cnt_issue", cnt_issue, 32'd0);
        chk("rp_cnt_stall", cnt_stall, 32'd0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk("rp_restart_mode", 32'(mode()), 32'b1000);
        chk("rp_restart_ready", 32'(in_ready), 32'd0);
        chk("rp_restart_keep", 32'(p_keep_res), 32'd1);
        push(5'd20, 1'b0);
        push(5'd21, 1'b1);
        next_cycle();
        @(negedge clk);
        chk("rp_mode1", 32'(mode()), 32'b0100);
        chk("rp_in_ready1", 32'(in_ready), 32'd1);
        next_cycle();
        in_valid = 1'b0;
        repeat (3) next_cycle();
        chk("rp_cnt_issue_after", cnt_issue, 32'd2);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
